// File: rtl/core_pkg.sv
// Shared definitions for the RV32I core front end: fetch/decode entry
// layout and the constants used by the fetch-to-decode buffer.
package core_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0,x0,0
    localparam int          FD_DEPTH  = 2;

    // One fetch packet as it travels from fetch to decode.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
    } fd_entry_t;

endpackage

// File: rtl/fd_entry_store.sv
// Entry storage for the fetch-to-decode buffer: one synchronous write port,
// one asynchronous read port, no reset (contents are don't-care until written).
module fd_entry_store
    import core_pkg::*;
#(
    parameter int DEPTH = FD_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [PTR_W-1:0] i_waddr,
    input  fd_entry_t        i_wdata,
    input  logic [PTR_W-1:0] i_raddr,
    output fd_entry_t        o_rdata
);

    fd_entry_t r_mem [DEPTH];

    // Write the incoming fetch packet into the addressed slot.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipe_reg_fd.sv
// Fetch-to-decode elastic pipeline register: a small FIFO that lets fetch
// run one extra cycle while decode stalls, and drops wrong-path packets
// when a taken branch/jump flushes decode.
//
// Handshake: a packet moves fetch->buffer on an edge where valid_F and
// ready_F are both high (and no flush); it moves buffer->decode on an edge
// where valid_D is high and stall_D is low (and no flush). ready_F depends
// only on the registered occupancy, never on stall_D, so there is no
// combinational path from decode back to fetch. Flush wins over everything.
module pipe_reg_fd
    import core_pkg::*;
#(
    parameter int               WIDTH = XLEN,
    parameter int               DEPTH = FD_DEPTH,
    parameter logic [WIDTH-1:0] NOP   = NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_F,
    input  logic [WIDTH-1:0] instr_F,
    input  logic [WIDTH-1:0] PC_F,
    input  logic [WIDTH-1:0] PCPlus4_F,
    output logic             ready_F,
    input  logic             flush_D,
    input  logic             stall_D,
    output logic             valid_D,
    output logic [WIDTH-1:0] instr_D,
    output logic [WIDTH-1:0] PC_D,
    output logic [WIDTH-1:0] PCPlus4_D
);

    localparam int               PTR_W = $clog2(DEPTH);
    localparam int               CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_ready;
    logic             w_valid;
    logic             w_push;
    logic             w_pop;
    fd_entry_t        w_wdata;
    fd_entry_t        w_rdata;

    assign w_ready = (r_count != FULL);
    assign w_valid = (r_count != '0);
    assign w_push  = valid_F & w_ready & ~flush_D;
    assign w_pop   = w_valid & ~stall_D & ~flush_D;

    assign w_wdata.instr    = instr_F;
    assign w_wdata.pc       = PC_F;
    assign w_wdata.pc_plus4 = PCPlus4_F;

    fd_entry_store #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_store (
        .i_clk   (clk),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // Pointer and occupancy tracking; a flush empties the buffer outright.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_D) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
            end
            if (w_pop) begin
                r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= CNT_W'(r_count + 1'b1);
                2'b01:   r_count <= CNT_W'(r_count - 1'b1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Decode sees the head entry, or a NOP bubble when the buffer is empty.
    assign ready_F   = w_ready;
    assign valid_D   = w_valid;
    assign instr_D   = w_valid ? w_rdata.instr    : NOP;
    assign PC_D      = w_valid ? w_rdata.pc       : '0;
    assign PCPlus4_D = w_valid ? w_rdata.pc_plus4 : '0;

endmodule

// File: tb/tb_pipe_reg_fd.sv
// Directed bench for pipe_reg_fd: reset, streaming, stall fill, flush,
// flush-over-stall, pointer wrap and asynchronous reset mid-stream.
module tb_pipe_reg_fd;

    localparam int          W   = 32;
    localparam logic [31:0] NOP = 32'h00000013;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_F;
    logic [W-1:0] instr_F;
    logic [W-1:0] PC_F;
    logic [W-1:0] PCPlus4_F;
    logic         ready_F;
    logic         flush_D;
    logic         stall_D;
    logic         valid_D;
    logic [W-1:0] instr_D;
    logic [W-1:0] PC_D;
    logic [W-1:0] PCPlus4_D;

    int n_checks = 0;
    int n_err    = 0;

    pipe_reg_fd dut (
        .clk       (clk),
        .rst       (rst),
        .valid_F   (valid_F),
        .instr_F   (instr_F),
        .PC_F      (PC_F),
        .PCPlus4_F (PCPlus4_F),
        .ready_F   (ready_F),
        .flush_D   (flush_D),
        .stall_D   (stall_D),
        .valid_D   (valid_D),
        .instr_D   (instr_D),
        .PC_D      (PC_D),
        .PCPlus4_D (PCPlus4_D)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk_instr(input logic [W-1:0] pc);
        return 32'hABC0_0000 ^ pc;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] pc);
        valid_F   = v;
        PC_F      = pc;
        instr_F   = mk_instr(pc);
        PCPlus4_F = pc + 32'd4;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [W-1:0] pc);
        chk({tag, "_valid"}, W'(valid_D), 32'd1);
        chk({tag, "_pc"},    PC_D,        pc);
        chk({tag, "_instr"}, instr_D,     mk_instr(pc));
        chk({tag, "_pc4"},   PCPlus4_D,   pc + 32'd4);
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_valid"}, W'(valid_D), 32'd0);
        chk({tag, "_instr"}, instr_D,     NOP);
        chk({tag, "_pc"},    PC_D,        32'd0);
        chk({tag, "_pc4"},   PCPlus4_D,   32'd0);
        chk({tag, "_ready"}, W'(ready_F), 32'd1);
    endtask

    initial begin
        int          occ;
        int          popped;
        logic [31:0] next_in;
        logic [31:0] exp_pop;
        logic        m_push;
        logic        m_pop;

        // reset
        rst     = 1'b1;
        flush_D = 1'b0;
        stall_D = 1'b0;
        drive(1'b0, 32'h0);
        #2;
        chk_empty("reset");
        step();
        step();
        rst = 1'b0;

        // stream 0,4,8 with no stall
        drive(1'b1, 32'h0);
        step();
        chk_head("stream0", 32'h0);
        chk("stream0_ready", W'(ready_F), 32'd1);
        drive(1'b1, 32'h4);
        step();
        chk_head("stream1", 32'h4);
        chk("stream1_ready", W'(ready_F), 32'd1);
        drive(1'b1, 32'h8);
        step();
        chk_head("stream2", 32'h8);
        chk("stream2_ready", W'(ready_F), 32'd1);
        drive(1'b0, 32'h0);
        step();
        chk_empty("drain");

        // stall fill: head 0x10, offer 0x14 then hold 0x18 for 3 stall cycles
        drive(1'b1, 32'h10);
        step();
        chk_head("fill_head", 32'h10);
        stall_D = 1'b1;
        drive(1'b1, 32'h14);
        step();
        chk_head("fill_s1", 32'h10);
        chk("fill_s1_ready", W'(ready_F), 32'd0);
        drive(1'b1, 32'h18);
        step();
        chk_head("fill_s2", 32'h10);
        chk("fill_s2_ready", W'(ready_F), 32'd0);
        step();
        chk_head("fill_s3", 32'h10);
        chk("fill_s3_ready", W'(ready_F), 32'd0);
        stall_D = 1'b0;
        step();
        chk_head("fill_out1", 32'h14);
        chk("fill_out1_ready", W'(ready_F), 32'd1);
        step();
        chk_head("fill_out2", 32'h18);
        drive(1'b0, 32'h0);
        step();
        chk_empty("fill_drain");

        // flush while holding 0x20, 0x24 and fetch offering 0x28
        stall_D = 1'b1;
        drive(1'b1, 32'h20);
        step();
        drive(1'b1, 32'h24);
        step();
        chk_head("flush_pre", 32'h20);
        chk("flush_pre_ready", W'(ready_F), 32'd0);
        stall_D = 1'b0;
        flush_D = 1'b1;
        drive(1'b1, 32'h28);
        step();
        chk_empty("flush_bubble");
        flush_D = 1'b0;
        drive(1'b1, 32'h100);
        step();
        chk_head("flush_redirect", 32'h100);
        drive(1'b0, 32'h0);
        step();
        chk_empty("flush_drain");

        // flush beats stall with a full buffer and a pending push
        stall_D = 1'b1;
        drive(1'b1, 32'h200);
        step();
        drive(1'b1, 32'h204);
        step();
        chk("fbs_full_ready", W'(ready_F), 32'd0);
        flush_D = 1'b1;
        drive(1'b1, 32'h208);
        step();
        chk_empty("fbs_flush");
        flush_D = 1'b0;
        stall_D = 1'b0;
        drive(1'b0, 32'h0);
        step();
        chk_empty("fbs_after");

        // wrap-around: 7 entries 0x0..0x18 with alternating stall
        occ     = 0;
        popped  = 0;
        next_in = 32'h0;
        exp_pop = 32'h0;
        for (int c = 0; c < 40 && popped < 7; c++) begin
            stall_D = c[0];
            drive(next_in <= 32'h18, next_in);
            chk("wrap_ready", W'(ready_F), W'(occ != 2));
            chk("wrap_valid", W'(valid_D), W'(occ != 0));
            m_push = valid_F && (occ != 2);
            m_pop  = (occ != 0) && !stall_D;
            if (m_pop) begin
                chk("wrap_order", PC_D, exp_pop);
                exp_pop = exp_pop + 32'd4;
                popped++;
            end
            step();
            occ = occ + int'(m_push) - int'(m_pop);
            if (m_push) next_in = next_in + 32'd4;
        end
        chk("wrap_count", W'(popped), 32'd7);
        stall_D = 1'b0;
        drive(1'b0, 32'h0);
        chk_empty("wrap_end");

        // asynchronous reset between edges with two entries held
        stall_D = 1'b1;
        drive(1'b1, 32'h300);
        step();
        drive(1'b1, 32'h304);
        step();
        chk("areset_pre_ready", W'(ready_F), 32'd0);
        drive(1'b0, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk_empty("areset");
        #1;
        rst     = 1'b0;
        stall_D = 1'b0;
        step();
        chk_empty("areset_after");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_reg_fd.md
Name: pipe_reg_fd

Overview:
- Fetch-to-decode elastic pipeline register for the 5-stage RV32I core.
- Captures instr_F, PC_F and PCPlus4_F from the fetch stage into a 2-entry buffer and presents the oldest entry to decode.
- Absorbs decode stalls through a ready/valid handshake and discards wrong-path instructions on a taken branch/jump flush.
- Replaces a plain IF/ID flop, so fetch can continue one extra cycle while decode is stalled.

Parameters:
WIDTH, 32, data width of instruction and PC fields
DEPTH, 2, number of buffer entries; power of two, ≥2
NOP, 32'h00000013, instruction driven to decode when the buffer is empty (addi x0,x0,0)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
valid_F  input  1  fetch presents a valid instruction this cycle
instr_F  input  WIDTH  fetched instruction
PC_F  input  WIDTH  PC of instr_F
PCPlus4_F  input  WIDTH  PC_F+4
ready_F  output  1  buffer can accept; fetch must hold PC when low
flush_D  input  1  taken control transfer resolved in execute (driven by PCsrc_E)
stall_D  input  1  decode cannot consume this cycle (load-use hazard)
valid_D  output  1  head entry valid
instr_D  output  WIDTH  head instruction
PC_D  output  WIDTH  head PC
PCPlus4_D  output  WIDTH  head PC+4

Behaviour:
- State: entry storage [DEPTH], wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH).
- Reset (asynchronous, rst=1):
  - count=0, wr_ptr=0, rd_ptr=0.
  - Outputs: valid_D=0, instr_D=NOP, PC_D=0, PCPlus4_D=0, ready_F=1.
  - Storage contents are don't-care.
- ready_F = (count != DEPTH). It is combinational from registered count only; no dependence on stall_D, so there is no combinational path from decode back to fetch.
- push = valid_F & ready_F & ~flush_D. On push, write {instr_F, PC_F, PCPlus4_F} at wr_ptr and increment wr_ptr.
- pop = valid_D & ~stall_D & ~flush_D. On pop, increment rd_ptr.
- count update: count + push - pop.
  - Simultaneous push and pop leaves count unchanged.
  - When full, push is blocked even if a pop occurs that cycle; there is no same-cycle bypass.
- Outputs:
  - valid_D = (count != 0).
  - When valid_D=1, instr_D/PC_D/PCPlus4_D = storage[rd_ptr].
  - When valid_D=0, outputs are NOP/0/0.
  - Outputs derive from registers only.
- Latency: an instruction pushed at edge N is visible on decode outputs after edge N, i.e. one cycle, when the buffer was empty.
- Flush (flush_D=1 at an edge):
  - count=0, rd_ptr=wr_ptr=0.
  - Any concurrent push is discarded, because it is wrong-path.
  - Any concurrent pop is suppressed.
  - Flush has priority over push, pop and stall.
  - In the next cycle valid_D=0 and instr_D=NOP, i.e. a bubble.
- Stall with count=1 and an incoming push: count goes to 2 and ready_F drops in the following cycle.
- Stall with count=2: state holds; ready_F=0; fetch must hold instr_F/PC_F.
- valid_F=0 with ready_F=1: no write, pointers unchanged.
- Reset mid-operation returns to the reset state immediately, independent of clk; entries in flight are lost.
- Ordering: strictly FIFO; entries are never reordered or duplicated.

Decomposition:
- Package core_pkg:
  - constants NOP_INSTR=32'h00000013 and FD_DEPTH=2;
  - typedef fd_entry_t packed struct {instr, pc, pc_plus4}, each WIDTH bits.
- One sub-module is natural: fd_entry_store.
  - Stores DEPTH×fd_entry_t.
  - Synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata); no reset.
  - Pointer, count and flush logic stay in pipe_reg_fd.

Test Plan:
- Reset then stream: release rst, and with stall_D=0 drive valid_F=1 and PC_F=0,4,8 on consecutive cycles. Required: PC_D=0,4,8 one cycle later, valid_D=1 throughout, ready_F=1 throughout.
- Stall fill: with count=1 (PC_D=0x10), hold stall_D=1 for 3 cycles while fetch offers 0x14 then holds 0x18. Required:
  - count reaches 2 and ready_F=0 from the second cycle;
  - after stall_D drops, PC_D sequence is 0x10, 0x14, 0x18 with no loss or duplication.
- Flush: buffer holds 0x20 and 0x24, fetch offers 0x28, assert flush_D for one cycle. Required:
  - next cycle valid_D=0, instr_D=0x00000013, ready_F=1;
  - next push (PC_F=0x100) appears as PC_D=0x100 one cycle later.
- Flush beats stall: with stall_D=1 and count=2, assert flush_D. Required: count=0 and valid_D=0 next cycle.
- Wrap-around: push/pop 7 entries PC 0x0..0x18 with alternating stall_D. Required: in-order output and correct pointer wrap past DEPTH.
- Async reset mid-stream: assert rst between clock edges while count=2. Required: valid_D=0, instr_D=NOP, ready_F=1 immediately, before the next edge.
